fp_add_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the RNN datapath. It is the next generation of the team's combinational FP32 adder. New capabilities:
- configurable exponent and mantissa widths
- add/subtract mode
- correct mixed-sign cancellation with leading-zero normalisation
- round-to-nearest-even, special-value handling and exception flags
- 3-stage pipeline with valid/ready backpressure
It sits between the MAC array and the activation units.

---
 rtl/fp_add_pkg.sv | 31 +++
 rtl/fp_add_pipe_lzc.sv | 26 ++
 rtl/fp_add_pipe.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
`default_nettype none
//==============================================================================
// Module : fp_add_pkg
// Shared constants and helpers for the pipelined floating-point adder.
// Rev    : 1.0
//==============================================================================
package fp_add_pkg;

    // Bit positions inside the 4-bit exception flag vector
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [31:0] CANON_NAN_FP32 = 32'h7FC0_0000;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Hidden bit + fraction + guard/round/sticky
    function automatic int xman_w_of(input int man_w);
        return man_w + 4;
    endfunction

endpackage : fp_add_pkg
`default_nettype wire

// File: rtl/fp_add_pipe_lzc.sv
`default_nettype none
//==============================================================================
// Module : lzc
// Parametrised leading-zero counter; an all-zero input reports W.
// Rev    : 1.0
//==============================================================================
module lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_count
);

    // The highest set bit is the last one visited, so it wins
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule : lzc
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
//==============================================================================
// Module : fp_add_pipe
// Three-stage IEEE-754-style adder/subtractor with RNE rounding and flags.
// Rev    : 1.0
//==============================================================================
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [3:0]               out_flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int XW  = xman_w_of(MAN_W);
    localparam int SW  = XW + 1;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + 2;

    localparam logic [W-1:0]         CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]     D_MAX     = EXP_W'(MAN_W + 3);
    localparam logic signed [EW-1:0] EMAX_S    = EW'(exp_max_of(EXP_W));
    localparam logic signed [EW-1:0] EZERO_S   = '0;

    typedef struct packed {
        logic             special;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flags;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [XW-1:0]    mx;
        logic [XW-1:0]    my;
    } s1_t;

    typedef struct packed {
        logic             special;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flags;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    mag;
        logic [LZW-1:0]   lz;
    } s2_t;

    s1_t            r_s1;
    s2_t            r_s2;
    logic           r_s1_valid;
    logic           r_s2_valid;
    logic           r_out_valid;
    logic [W-1:0]   r_out_result;
    logic [3:0]     r_out_flags;

    logic           w_advance;
    s1_t            w_s1;
    s2_t            w_s2;
    logic [W-1:0]   w_res;
    logic [3:0]     w_flags;

    assign w_advance  = !r_out_valid || out_ready;
    assign in_ready   = w_advance;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

    //--------------------------------------------------------------------------
    // S1: decode, order by magnitude, align the smaller operand
    //--------------------------------------------------------------------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_d;
    logic [MAN_W-1:0] w_fa, w_fb, w_fx, w_fy;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_swap;
    logic [XW-1:0]    w_ext_y, w_lost;

    assign w_sa     = in_a[W-1];
    assign w_sb     = in_b[W-1] ^ in_sub;
    assign w_ea     = in_a[W-2 -: EXP_W];
    assign w_eb     = in_b[W-2 -: EXP_W];
    assign w_fa     = in_a[MAN_W-1:0];
    assign w_fb     = in_b[MAN_W-1:0];
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);
    assign w_a_inf  = (&w_ea) && !(|w_fa);
    assign w_b_inf  = (&w_eb) && !(|w_fb);
    assign w_a_zero = ~|w_ea;
    assign w_b_zero = ~|w_eb;
    assign w_swap   = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_ex     = w_swap ? w_eb : w_ea;
    assign w_ey     = w_swap ? w_ea : w_eb;
    assign w_fx     = w_swap ? w_fb : w_fa;
    assign w_fy     = w_swap ? w_fa : w_fb;
    assign w_d      = w_ex - w_ey;
    assign w_ext_y  = {1'b1, w_fy, 3'b000};
    assign w_lost   = w_ext_y & ~({XW{1'b1}} << w_d);

    always_comb begin
        w_s1            = '0;
        w_s1.sign       = w_swap ? w_sb : w_sa;
        w_s1.eff_sub    = w_sa ^ w_sb;
        w_s1.exp        = w_ex;
        w_s1.mx         = {1'b1, w_fx, 3'b000};
        if (w_d >= D_MAX) begin
            w_s1.my = {{(XW-1){1'b0}}, 1'b1};
        end else begin
            w_s1.my = (w_ext_y >> w_d) | {{(XW-1){1'b0}}, |w_lost};
        end

        // Specials bypass the arithmetic path and ride along to S3
        if (w_a_nan || w_b_nan) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = CANON_NAN;
        end else if (w_a_inf && w_b_inf) begin
            w_s1.special = 1'b1;
            if (w_sa != w_sb) begin
                w_s1.spec_res                 = CANON_NAN;
                w_s1.spec_flags[FLAG_INVALID] = 1'b1;
            end else begin
                w_s1.spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (w_a_inf) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = {w_sb, w_eb, w_fb};
        end else if (w_b_zero) begin
            w_s1.special  = 1'b1;
            w_s1.spec_res = in_a;
        end
    end

    //--------------------------------------------------------------------------
    // S2: magnitude add/subtract and leading-zero count
    //--------------------------------------------------------------------------
    logic [SW-1:0]  w_mag;
    logic [LZW-1:0] w_lz;

    assign w_mag = r_s1.eff_sub ? ({1'b0, r_s1.mx} - {1'b0, r_s1.my})
                                : ({1'b0, r_s1.mx} + {1'b0, r_s1.my});

    lzc #(
        .W (SW)
    ) u_lzc (
        .i_vec   (w_mag),
        .o_count (w_lz)
    );

    always_comb begin
        w_s2            = '0;
        w_s2.special    = r_s1.special;
        w_s2.spec_res   = r_s1.spec_res;
        w_s2.spec_flags = r_s1.spec_flags;
        w_s2.sign       = r_s1.sign;
        w_s2.exp        = r_s1.exp;
        w_s2.mag        = w_mag;
        w_s2.lz         = w_lz;
    end

    //--------------------------------------------------------------------------
    // S3: normalise, round to nearest even, range check, pack
    //--------------------------------------------------------------------------
    logic                 w_carry, w_g, w_r, w_s, w_up, w_inexact;
    logic [LZW-1:0]       w_lsh;
    logic [XW-1:0]        w_norm;
    logic [MAN_W+1:0]     w_man;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_e, w_er;

    assign w_carry = r_s2.mag[SW-1];
    // Leading one belongs one below the carry position
    assign w_lsh   = r_s2.lz - LZW'(1);

    always_comb begin
        if (w_carry) begin
            w_norm = {r_s2.mag[SW-1:2], |r_s2.mag[1:0]};
            w_e    = EW'(r_s2.exp) + EW'(1);
        end else begin
            w_norm = XW'(r_s2.mag << w_lsh);
            w_e    = EW'(r_s2.exp) - EW'(w_lsh);
        end
    end

    assign w_g       = w_norm[2];
    assign w_r       = w_norm[1];
    assign w_s       = w_norm[0];
    assign w_inexact = w_g || w_r || w_s;
    assign w_up      = w_g && (w_r || w_s || w_norm[3]);
    assign w_man     = {1'b0, w_norm[XW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_er      = w_man[MAN_W+1] ? (w_e + EW'(1)) : w_e;
    assign w_frac    = w_man[MAN_W+1] ? w_man[MAN_W:1] : w_man[MAN_W-1:0];

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (r_s2.special) begin
            w_res   = r_s2.spec_res;
            w_flags = r_s2.spec_flags;
        end else if (~|r_s2.mag) begin
            w_res = '0;
        end else if (w_er >= EMAX_S) begin
            w_res                   = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[FLAG_OVERFLOW]  = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
        end else if (w_er <= EZERO_S) begin
            w_res                   = {r_s2.sign, {(W-1){1'b0}}};
            w_flags[FLAG_UNDERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            w_res                   = {r_s2.sign, w_er[EXP_W-1:0], w_frac};
            w_flags[FLAG_INEXACT]   = w_inexact;
        end
    end

    //--------------------------------------------------------------------------
    // Pipeline registers: everything moves together or holds together
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (w_advance) begin
            r_s1_valid   <= in_valid;
            r_s2_valid   <= r_s1_valid;
            r_out_valid  <= r_s2_valid;
            r_s1         <= w_s1;
            r_s2         <= w_s2;
            r_out_result <= w_res;
            r_out_flags  <= w_flags;
        end
    end

endmodule : fp_add_pipe
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
//==============================================================================
// Module : tb_fp_add_pipe
// Scoreboard bench for fp_add_pipe (FP32 configuration).
// Rev    : 1.0
//==============================================================================
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 24;
    // flags are {invalid, overflow, underflow, inexact}
    vec_t vt [NV] = '{
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},
        '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
        '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
        '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000},
        '{32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 4'b0000},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
        '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011},
        '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000},
        '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001},
        '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001},
        '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},
        '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000},
        '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000}
    };

    exp_t sb [$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_popped = 0;
    bit   drv_done = 1'b0;

    fp_add_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Output side of the scoreboard: every transfer out pops one expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h flags %b, required no output", out_result, out_flags);
            end else begin
                e = sb.pop_front();
                n_popped++;
                if ({out_result, out_flags} !== e) begin
                    n_fail++;
                    $display("FAIL result: got %h flags %b, required %h flags %b",
                             out_result, out_flags, e.res, e.flags);
                end
            end
        end
    end

    // Entered just after a rising edge; leaves just after the accepting edge
    task automatic send_op(input vec_t v);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_sub   = v.sub;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({v.r, v.f});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1");
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_tests++;
        if (out_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_result: got %h, required 00000000", out_result);
        end
        n_tests++;
        if (out_flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_out_flags: got %b, required 0000", out_flags);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic exp_v;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = vt[0].a;
        in_b      = vt[0].b;
        in_sub    = vt[0].sub;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_in_ready: got %b, required 1", in_ready);
        end
        sb.push_back({vt[0].r, vt[0].f});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp_v = (k == 3);
            n_tests++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL latency_edge%0d: out_valid got %b, required %b", k, out_valid, exp_v);
            end
            if (k < 3) @(posedge clk);
        end
        @(posedge clk);
        #1;
        wait_drain("latency");
    endtask

    task automatic test_vectors();
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send_op(vt[i]);
        wait_drain("vectors");
    endtask

    task automatic test_back_to_back();
        vec_t ops [6];
        int   p0;
        ops[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        ops[1] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        ops[2] = '{32'h3F800000, 32'h40400000, 1'b0, 32'h40800000, 4'b0000};
        ops[3] = '{32'h3F800000, 32'h40800000, 1'b0, 32'h40A00000, 4'b0000};
        ops[4] = '{32'h3F800000, 32'h40A00000, 1'b0, 32'h40C00000, 4'b0000};
        ops[5] = '{32'h3F800000, 32'h40C00000, 1'b0, 32'h40E00000, 4'b0000};
        p0 = n_popped;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_op(ops[i]);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k >= 3) begin
                        n_tests++;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stall_full_c%0d: in_ready/out_valid got %b/%b, required 0/1",
                                     k, in_ready, out_valid);
                        end
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("back_to_back");
        n_tests++;
        if (n_popped - p0 != 6) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d results, required 6", n_popped - p0);
        end
    endtask

    task automatic test_random_stall();
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < NV; i++) send_op(vt[i]);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_stall");
    endtask

    task automatic test_reset_midstream();
        int bad;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_op(vt[i]);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got valid %b result %h flags %b, required 0 00000000 0000",
                     out_valid, out_result, out_flags);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL restart_empty: got %0d cycles with out_valid, required 0", bad);
        end
        @(posedge clk);
        #1;
        send_op(vt[4]);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_random_stall();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp_add_pipe
`default_nettype wire
